// File: rtl/reg_map_shadow.sv
// Shadow/active double-buffered register map with atomic commit.
// Host writes land in the shadow set; a commit copies the whole shadow set to the active outputs in one edge.
module reg_map_shadow #(
  parameter int                           DATA_W      = 16,
  parameter int                           ADDR_W      = 16,
  parameter int                           NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]            BASE_ADDR   = '0,
  parameter int                           ADDR_STRIDE = 2,
  parameter logic [NUM_REGS*DATA_W-1:0]   RST_VALS    = '0,
  parameter logic [NUM_REGS-1:0]          AUTO_COMMIT = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_wen,
  input  logic                       i_commit,
  output logic [DATA_W-1:0]          o_q,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic                       o_pending,
  output logic                       o_commit
);

  localparam int                STRIDE_SH   = (ADDR_STRIDE == 4) ? 2 : (ADDR_STRIDE == 2) ? 1 : 0;
  localparam logic [ADDR_W-1:0] STRIDE_MASK = ADDR_W'(ADDR_STRIDE - 1);
  localparam logic [ADDR_W-1:0] CMT_ADDR    = ADDR_W'(BASE_ADDR + NUM_REGS * ADDR_STRIDE);

  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];

  logic              borrow;
  logic [ADDR_W-1:0] addr_off;
  logic [ADDR_W-1:0] word_idx;
  logic              data_hit;
  logic              cmt_hit;
  logic [NUM_REGS-1:0] reg_sel;
  logic [NUM_REGS-1:0] wr_en;
  logic              manual_wr;
  logic              commit_req;
  logic [DATA_W-1:0] rd_mux;

  logic [DATA_W-1:0] rd_data_p1;
  logic              pending_p1;
  logic              commit_p1;

  // Decode: the borrow out of the offset subtraction blocks aliasing below BASE_ADDR
  always_comb begin
    {borrow, addr_off} = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    word_idx = addr_off >> STRIDE_SH;
    data_hit = !borrow && ((addr_off & STRIDE_MASK) == '0) && (word_idx < ADDR_W'(NUM_REGS));
    cmt_hit  = (i_addr == CMT_ADDR);
    reg_sel  = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      reg_sel[j] = data_hit && (word_idx == ADDR_W'(j));
    end
    wr_en      = {NUM_REGS{i_wen}} & reg_sel;
    manual_wr  = |(wr_en & ~AUTO_COMMIT);
    commit_req = i_commit || (i_wen && cmt_hit && i_wdata[0]);
  end

  // Read mux sees pre-write shadow contents, so a write cycle returns the old value
  always_comb begin
    rd_mux = '0;
    if (cmt_hit) begin
      rd_mux = DATA_W'(pending_p1);
    end
    for (int j = 0; j < NUM_REGS; j++) begin
      if (reg_sel[j]) begin
        rd_mux = shadow[j];
      end
    end
  end

  // Stage p0 -> p1: register file update and registered read-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < NUM_REGS; j++) begin
        shadow[j] <= RST_VALS[j*DATA_W +: DATA_W];
        active[j] <= RST_VALS[j*DATA_W +: DATA_W];
      end
      rd_data_p1 <= '0;
      pending_p1 <= 1'b0;
      commit_p1  <= 1'b0;
    end else begin
      rd_data_p1 <= rd_mux;
      commit_p1  <= commit_req;
      for (int j = 0; j < NUM_REGS; j++) begin
        if (wr_en[j]) begin
          shadow[j] <= i_wdata;
        end
        // An auto-commit write beats a simultaneous commit; a manual register takes its pre-write shadow
        if (wr_en[j] && AUTO_COMMIT[j]) begin
          active[j] <= i_wdata;
        end else if (commit_req) begin
          active[j] <= shadow[j];
        end
      end
      if (manual_wr) begin
        pending_p1 <= 1'b1;
      end else if (commit_req) begin
        pending_p1 <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign o_regs[g*DATA_W +: DATA_W] = active[g];
  end

  assign o_q       = rd_data_p1;
  assign o_pending = pending_p1;
  assign o_commit  = commit_p1;

endmodule

// File: doc/reg_map_shadow.md
Name: reg_map_shadow

Overview:
- Parametrised successor to the fixed four-register FF register map behind uart2reg_if.
- N generic registers with a shadow/active double-buffer and an atomic commit.
- Multi-word settings (e.g. the 32-bit RF NCO frequency split over two 16-bit words) reach fmSigMix/nco_tx in one clock, never half-updated.
- Sits in the clk50m domain between uart2reg_if and the DSP blocks.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 16, host address width.
- NUM_REGS, 8, number of data registers (1..32).
- BASE_ADDR, 16'h0000, address of register 0.
- ADDR_STRIDE, 2, address step between registers (1, 2 or 4).
- RST_VALS, all-zero, NUM_REGS*DATA_W flat vector of reset values; register i uses bits [i*DATA_W +: DATA_W].
- AUTO_COMMIT, all-zero, NUM_REGS-bit mask; bit i=1 means writes to register i also update its active copy immediately.

Ports:
- i_clk  in  1  system clock (clk50m).
- i_rst_n  in  1  asynchronous active-low reset.
- i_addr  in  ADDR_W  host read/write address, valid every cycle.
- i_wdata  in  DATA_W  write data.
- i_wen  in  1  write strobe, one cycle per write.
- i_commit  in  1  external commit strobe (e.g. audio frame sync).
- o_q  out  DATA_W  registered read data.
- o_regs  out  NUM_REGS*DATA_W  flat vector of active values; register i at [i*DATA_W +: DATA_W].
- o_pending  out  1  shadow differs from active by at least one uncommitted write.
- o_commit  out  1  one-cycle pulse: the active set changed by commit.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset state: shadow[i] and active[i] = RST_VALS slice; o_q=0; o_pending=0; o_commit=0. Reset asserted mid-sequence discards all uncommitted shadow writes.
- Decode:
  - Data index i = (i_addr-BASE_ADDR)/ADDR_STRIDE.
  - A data address is valid only if i_addr>=BASE_ADDR, (i_addr-BASE_ADDR) mod ADDR_STRIDE==0 and i<NUM_REGS.
  - CMT_ADDR = BASE_ADDR + NUM_REGS*ADDR_STRIDE.
  - All other addresses are unmapped.
- Data write: i_wen on a valid data address takes effect at the next edge.
  - shadow[i] <= i_wdata.
  - If AUTO_COMMIT[i]=1, active[i] <= i_wdata on the same edge and o_pending is unaffected.
  - Otherwise o_pending <= 1.
- Commit triggers: i_wen at CMT_ADDR with i_wdata[0]=1, or i_commit=1.
  - On the next edge: active[j] <= shadow[j] for all j; o_pending <= 0; o_commit <= 1 for exactly one cycle.
  - Both triggers in the same cycle produce a single commit and a single pulse.
  - A commit with o_pending=0 still pulses o_commit.
- Simultaneous i_commit and a data write to register i:
  - Non-auto register: active[i] receives the pre-write shadow[i]; shadow[i] receives i_wdata; o_pending ends at 1.
  - Auto register: active[i] receives i_wdata (the write wins).
- Writes to CMT_ADDR with i_wdata[0]=0, and writes to unmapped addresses, are ignored with no state change.
- Read: o_q <= mux(i_addr) every cycle, independent of i_wen, with 1-cycle latency.
  - Data address returns shadow[i]. During a write cycle it returns the value before the write.
  - CMT_ADDR returns {zeros, o_pending}.
  - Unmapped addresses return 0.
- o_regs is driven directly from the active registers and changes only on a commit or an auto-commit write.
- Width rules: address arithmetic is unsigned at ADDR_W bits. The subtraction is not taken when i_addr<BASE_ADDR, so there is no wrap-around aliasing.

Test Plan:
- Reset: NUM_REGS=4, RST_VALS={16'h0004,16'h0003,16'h0002,16'h0001} -> o_regs slices 1,2,3,4; read of addr 2 gives o_q=16'h0002 one cycle later; o_pending=0.
- Atomic frequency update:
  - Write 0x0000=16'h5678, then 0x0002=16'h1234 -> o_regs unchanged, o_pending=1, read-back shows the shadow values.
  - Then write CMT_ADDR=0x0001 -> both slices update on the same edge, o_commit high one cycle, o_pending=0.
- Auto-commit: AUTO_COMMIT=4'b0100; write 0x0004=16'h00AA -> active[2]=16'h00AA on the next edge, o_pending stays 0, o_commit stays 0.
- Boundary decode:
  - Writes to 0x0003 (misaligned), 0x000A (beyond CMT_ADDR=0x0008) and BASE_ADDR-2 with BASE_ADDR=0x0010 -> no state change; reads return 0.
  - Write CMT_ADDR=0x0000 -> ignored.
- Simultaneous events:
  - shadow[1]=16'h0011 pending; assert i_commit in the same cycle as a write 0x0002=16'h0022 -> active[1]=16'h0011, shadow[1]=16'h0022, o_pending=1.
  - A second i_commit -> active[1]=16'h0022.
- Reset mid-operation: write 0x0000=16'hBEEF, pulse i_rst_n low for 3 ns off-edge -> shadow and active return to RST_VALS immediately (asynchronously); o_pending=0; a subsequent commit leaves o_regs at RST_VALS.
